// File: rtl/billiard_pkg.sv
// Shared types and helpers for the billiard ball datapath.
// Positions are fixed point with FRAC_BITS fractional bits; velocities are sub-pixels per frame.
package billiard_pkg;

    localparam int FRAC_BITS_DEF = 6;

    typedef logic signed [10:0] vel_t;
    typedef logic signed [16:0] fpos_t;

    typedef enum logic {
        IDLE,
        MOVING
    } ball_state_t;

    function automatic vel_t clamp_vel(input vel_t v, input int max_vel);
        int v_int;
        v_int = int'(v);
        if (v_int > max_vel) begin
            return vel_t'(max_vel);
        end else if (v_int < -max_vel) begin
            return vel_t'(-max_vel);
        end
        return v;
    endfunction

    // Saturating add; the wide intermediate keeps the position from ever wrapping.
    function automatic fpos_t integrate_pos(input fpos_t pos, input vel_t vel, input int lim);
        int sum;
        sum = int'(pos) + int'(vel);
        if (sum < 0) begin
            sum = 0;
        end else if (sum > lim) begin
            sum = lim;
        end
        return fpos_t'(sum);
    endfunction

endpackage

// File: rtl/friction_step.sv
// Moves one velocity component a single unit toward zero when enabled.
// Never crosses zero, so the sign of the component is preserved.
module friction_step (
    input  logic signed [10:0] i_vel,
    input  logic               i_enable,
    output logic signed [10:0] o_vel
);

    always_comb begin
        o_vel = i_vel;
        if (i_enable) begin
            if (i_vel > 11'sd0) begin
                o_vel = i_vel - 11'sd1;
            end else if (i_vel < 11'sd0) begin
                o_vel = i_vel + 11'sd1;
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics: owns position and velocity, integrates once per frame,
// applies periodic friction, accepts cue shots and reflected velocities from border_collision.
module ball_motion
    import billiard_pkg::*;
#(
    parameter int INIT_X          = 320,
    parameter int INIT_Y          = 240,
    parameter int FRAC_BITS       = FRAC_BITS_DEF,
    parameter int FRICTION_PERIOD = 4,
    parameter int HIT_HOLDOFF     = 3,
    parameter int MAX_VEL         = 511,
    parameter int X_MAX           = 623,
    parameter int Y_MAX           = 463
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_startOfFrame,
    input  logic               i_shotValid,
    input  logic signed [10:0] i_shotVelX,
    input  logic signed [10:0] i_shotVelY,
    input  logic               i_collisionOccurred,
    input  logic signed [10:0] i_collVelX,
    input  logic signed [10:0] i_collVelY,
    output logic signed [10:0] o_ballPosX,
    output logic signed [10:0] o_ballPosY,
    output logic signed [10:0] o_ballVelX,
    output logic signed [10:0] o_ballVelY,
    output logic               o_ballMoving
);

    localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam int HO_W  = (HIT_HOLDOFF > 1) ? $clog2(HIT_HOLDOFF + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);
    localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HIT_HOLDOFF);

    localparam int POS_X_LIM = X_MAX << FRAC_BITS;
    localparam int POS_Y_LIM = Y_MAX << FRAC_BITS;

    localparam fpos_t POS_X_RST = fpos_t'(INIT_X << FRAC_BITS);
    localparam fpos_t POS_Y_RST = fpos_t'(INIT_Y << FRAC_BITS);

    ball_state_t      r_state;
    ball_state_t      w_stateNext;
    fpos_t            r_posX;
    fpos_t            r_posY;
    fpos_t            w_posXNext;
    fpos_t            w_posYNext;
    vel_t             r_velX;
    vel_t             r_velY;
    vel_t             w_velXNext;
    vel_t             w_velYNext;
    logic [CNT_W-1:0] r_frictionCnt;
    logic [CNT_W-1:0] w_frictionCntNext;
    logic [HO_W-1:0]  r_holdoff;
    logic [HO_W-1:0]  w_holdoffNext;

    vel_t             r_outPosX;
    vel_t             r_outPosY;
    vel_t             r_outVelX;
    vel_t             r_outVelY;
    logic             r_outMoving;

    vel_t             w_shotX;
    vel_t             w_shotY;
    vel_t             w_fricVelX;
    vel_t             w_fricVelY;
    logic             w_frameTick;
    logic             w_collAccept;
    logic             w_frictionEn;

    assign w_shotX      = clamp_vel(i_shotVelX, MAX_VEL);
    assign w_shotY      = clamp_vel(i_shotVelY, MAX_VEL);
    assign w_frameTick  = i_startOfFrame && (r_state == MOVING);
    assign w_collAccept = i_collisionOccurred && (r_holdoff == '0) && (r_state == MOVING);
    // A collision on the friction frame replaces the velocity outright, so no step that frame.
    assign w_frictionEn = w_frameTick && (r_frictionCnt == CNT_LAST) && !w_collAccept;

    friction_step u_friction_x (
        .i_vel    (r_velX),
        .i_enable (w_frictionEn),
        .o_vel    (w_fricVelX)
    );

    friction_step u_friction_y (
        .i_vel    (r_velY),
        .i_enable (w_frictionEn),
        .o_vel    (w_fricVelY)
    );

    always_comb begin
        w_stateNext       = r_state;
        w_posXNext        = r_posX;
        w_posYNext        = r_posY;
        w_velXNext        = r_velX;
        w_velYNext        = r_velY;
        w_frictionCntNext = r_frictionCnt;
        w_holdoffNext     = r_holdoff;

        unique case (r_state)
            IDLE: begin
                if (i_shotValid) begin
                    w_velXNext = w_shotX;
                    w_velYNext = w_shotY;
                    if ((w_shotX != '0) || (w_shotY != '0)) begin
                        w_stateNext = MOVING;
                    end
                end
            end

            MOVING: begin
                if (w_frameTick) begin
                    w_posXNext = integrate_pos(r_posX, r_velX, POS_X_LIM);
                    w_posYNext = integrate_pos(r_posY, r_velY, POS_Y_LIM);
                    if (r_frictionCnt == CNT_LAST) begin
                        w_frictionCntNext = '0;
                    end else begin
                        w_frictionCntNext = r_frictionCnt + CNT_W'(1);
                    end
                    if (r_holdoff != '0) begin
                        w_holdoffNext = r_holdoff - HO_W'(1);
                    end
                end

                if (w_collAccept) begin
                    w_velXNext    = i_collVelX;
                    w_velYNext    = i_collVelY;
                    w_holdoffNext = HO_LOAD;
                end else begin
                    w_velXNext = w_fricVelX;
                    w_velYNext = w_fricVelY;
                end

                if ((r_velX == '0) && (r_velY == '0) && !w_collAccept) begin
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE;
            r_posX        <= POS_X_RST;
            r_posY        <= POS_Y_RST;
            r_velX        <= '0;
            r_velY        <= '0;
            r_frictionCnt <= '0;
            r_holdoff     <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_posX        <= w_posXNext;
            r_posY        <= w_posYNext;
            r_velX        <= w_velXNext;
            r_velY        <= w_velYNext;
            r_frictionCnt <= w_frictionCntNext;
            r_holdoff     <= w_holdoffNext;
        end
    end

    // Outputs lag the state registers by one cycle; the shift floors toward -inf.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_outPosX   <= vel_t'(INIT_X);
            r_outPosY   <= vel_t'(INIT_Y);
            r_outVelX   <= '0;
            r_outVelY   <= '0;
            r_outMoving <= 1'b0;
        end else begin
            r_outPosX   <= vel_t'(r_posX >>> FRAC_BITS);
            r_outPosY   <= vel_t'(r_posY >>> FRAC_BITS);
            r_outVelX   <= r_velX;
            r_outVelY   <= r_velY;
            r_outMoving <= (r_state == MOVING);
        end
    end

    assign o_ballPosX   = r_outPosX;
    assign o_ballPosY   = r_outPosY;
    assign o_ballVelX   = r_outVelX;
    assign o_ballVelY   = r_outVelY;
    assign o_ballMoving = r_outMoving;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with hand-computed expectations.
module tb_ball_motion;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               i_startOfFrame = 1'b0;
    logic               i_shotValid = 1'b0;
    logic signed [10:0] i_shotVelX = '0;
    logic signed [10:0] i_shotVelY = '0;
    logic               i_collisionOccurred = 1'b0;
    logic signed [10:0] i_collVelX = '0;
    logic signed [10:0] i_collVelY = '0;
    logic signed [10:0] o_ballPosX;
    logic signed [10:0] o_ballPosY;
    logic signed [10:0] o_ballVelX;
    logic signed [10:0] o_ballVelY;
    logic               o_ballMoving;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk                 (clk),
        .resetN              (resetN),
        .i_startOfFrame      (i_startOfFrame),
        .i_shotValid         (i_shotValid),
        .i_shotVelX          (i_shotVelX),
        .i_shotVelY          (i_shotVelY),
        .i_collisionOccurred (i_collisionOccurred),
        .i_collVelX          (i_collVelX),
        .i_collVelY          (i_collVelY),
        .o_ballPosX          (o_ballPosX),
        .o_ballPosY          (o_ballPosY),
        .o_ballVelX          (o_ballVelX),
        .o_ballVelY          (o_ballVelY),
        .o_ballMoving        (o_ballMoving)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetN              = 1'b0;
        i_startOfFrame      = 1'b0;
        i_shotValid         = 1'b0;
        i_collisionOccurred = 1'b0;
        i_shotVelX          = '0;
        i_shotVelY          = '0;
        i_collVelX          = '0;
        i_collVelY          = '0;
        step(2);
        resetN = 1'b1;
        step(1);
    endtask

    task automatic frame();
        i_startOfFrame = 1'b1;
        step(1);
        i_startOfFrame = 1'b0;
        step(2);
    endtask

    task automatic shot(input logic signed [10:0] x, input logic signed [10:0] y);
        i_shotVelX  = x;
        i_shotVelY  = y;
        i_shotValid = 1'b1;
        step(1);
        i_shotValid = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (o_ballPosX !== 11'sd320) begin
            errors++; $display("FAIL reset_posx: got %0d want 320", o_ballPosX);
        end
        vectors++;
        if (o_ballPosY !== 11'sd240) begin
            errors++; $display("FAIL reset_posy: got %0d want 240", o_ballPosY);
        end
        vectors++;
        if (o_ballVelX !== 11'sd0 || o_ballVelY !== 11'sd0) begin
            errors++; $display("FAIL reset_vel: got %0d/%0d want 0/0", o_ballVelX, o_ballVelY);
        end
        vectors++;
        if (o_ballMoving !== 1'b0) begin
            errors++; $display("FAIL reset_moving: got %0b want 0", o_ballMoving);
        end
    endtask

    task automatic test_shot();
        do_reset();
        shot(11'sd64, 11'sd0);
        vectors++;
        if (o_ballMoving !== 1'b1 || o_ballVelX !== 11'sd64) begin
            errors++; $display("FAIL shot_start: moving %0b vel %0d want 1 64", o_ballMoving, o_ballVelX);
        end
        frame();
        vectors++;
        if (o_ballPosX !== 11'sd321) begin
            errors++; $display("FAIL shot_pos1: got %0d want 321", o_ballPosX);
        end
        frame();
        frame();
        vectors++;
        if (o_ballVelX !== 11'sd64) begin
            errors++; $display("FAIL shot_vel3: got %0d want 64", o_ballVelX);
        end
        frame();
        vectors++;
        if (o_ballVelX !== 11'sd63) begin
            errors++; $display("FAIL shot_fric4: got %0d want 63", o_ballVelX);
        end
        vectors++;
        if (o_ballPosX !== 11'sd324) begin
            errors++; $display("FAIL shot_pos4: got %0d want 324", o_ballPosX);
        end
    endtask

    task automatic test_stop();
        do_reset();
        shot(-11'sd2, 11'sd1);
        repeat (7) frame();
        vectors++;
        if (o_ballVelX !== -11'sd1 || o_ballVelY !== 11'sd0 || o_ballMoving !== 1'b1) begin
            errors++; $display("FAIL stop_f7: vel %0d/%0d moving %0b want -1/0 1",
                               o_ballVelX, o_ballVelY, o_ballMoving);
        end
        i_startOfFrame = 1'b1;
        step(1);
        i_startOfFrame = 1'b0;
        step(1);
        vectors++;
        if (o_ballVelX !== 11'sd0 || o_ballVelY !== 11'sd0 || o_ballMoving !== 1'b1) begin
            errors++; $display("FAIL stop_f8: vel %0d/%0d moving %0b want 0/0 1",
                               o_ballVelX, o_ballVelY, o_ballMoving);
        end
        step(1);
        vectors++;
        if (o_ballMoving !== 1'b0) begin
            errors++; $display("FAIL stop_idle: moving %0b want 0", o_ballMoving);
        end
        vectors++;
        if (o_ballPosX !== 11'sd319 || o_ballPosY !== 11'sd240) begin
            errors++; $display("FAIL stop_pos: got %0d,%0d want 319,240", o_ballPosX, o_ballPosY);
        end
        repeat (3) frame();
        vectors++;
        if (o_ballPosX !== 11'sd319 || o_ballPosY !== 11'sd240) begin
            errors++; $display("FAIL stop_stable: got %0d,%0d want 319,240", o_ballPosX, o_ballPosY);
        end
    endtask

    // Ports are 11-bit, so +-1000 / -1024 stand in for out-of-range shot speeds.
    task automatic test_clamp();
        do_reset();
        shot(11'sd1000, 11'sd0);
        vectors++;
        if (o_ballVelX !== 11'sd511 || o_ballMoving !== 1'b1) begin
            errors++; $display("FAIL clamp_pos: vel %0d moving %0b want 511 1", o_ballVelX, o_ballMoving);
        end
        shot(-11'sd1000, 11'sd5);
        vectors++;
        if (o_ballVelX !== 11'sd511 || o_ballVelY !== 11'sd0) begin
            errors++; $display("FAIL clamp_ignore: vel %0d/%0d want 511/0", o_ballVelX, o_ballVelY);
        end
        do_reset();
        shot(-11'sd1000, -11'sd1024);
        vectors++;
        if (o_ballVelX !== -11'sd511 || o_ballVelY !== -11'sd511) begin
            errors++; $display("FAIL clamp_neg: vel %0d/%0d want -511/-511", o_ballVelX, o_ballVelY);
        end
        do_reset();
        shot(11'sd0, 11'sd0);
        vectors++;
        if (o_ballMoving !== 1'b0) begin
            errors++; $display("FAIL clamp_zero: moving %0b want 0", o_ballMoving);
        end
    endtask

    task automatic test_collision_hold();
        logic signed [10:0] exp_vel;
        do_reset();
        shot(11'sd64, 11'sd0);
        i_collVelX          = -11'sd64;
        i_collVelY          = 11'sd0;
        i_collisionOccurred = 1'b1;
        step(50);
        i_collisionOccurred = 1'b0;
        i_collVelX          = 11'sd100;
        step(1);
        vectors++;
        if (o_ballVelX !== -11'sd64) begin
            errors++; $display("FAIL coll_hold: got %0d want -64", o_ballVelX);
        end
        for (int f = 1; f <= 3; f++) begin
            frame();
            i_collisionOccurred = 1'b1;
            step(1);
            i_collisionOccurred = 1'b0;
            step(2);
            exp_vel = (f < 3) ? -11'sd64 : 11'sd100;
            vectors++;
            if (o_ballVelX !== exp_vel) begin
                errors++; $display("FAIL coll_frame%0d: got %0d want %0d", f, o_ballVelX, exp_vel);
            end
        end
    endtask

    task automatic test_coincident();
        do_reset();
        shot(11'sd64, 11'sd0);
        repeat (3) frame();
        vectors++;
        if (o_ballPosX !== 11'sd323) begin
            errors++; $display("FAIL coin_pre: got %0d want 323", o_ballPosX);
        end
        i_collVelX          = -11'sd64;
        i_collVelY          = 11'sd0;
        i_startOfFrame      = 1'b1;
        i_collisionOccurred = 1'b1;
        step(1);
        i_startOfFrame      = 1'b0;
        i_collisionOccurred = 1'b0;
        step(2);
        vectors++;
        if (o_ballPosX !== 11'sd324 || o_ballVelX !== -11'sd64) begin
            errors++; $display("FAIL coin_frame: pos %0d vel %0d want 324 -64", o_ballPosX, o_ballVelX);
        end
        frame();
        vectors++;
        if (o_ballPosX !== 11'sd323 || o_ballVelX !== -11'sd64) begin
            errors++; $display("FAIL coin_next: pos %0d vel %0d want 323 -64", o_ballPosX, o_ballVelX);
        end
    endtask

    task automatic test_saturate();
        logic               mono;
        logic signed [10:0] prev;
        do_reset();
        shot(11'sd1000, 11'sd0);
        mono = 1'b1;
        prev = o_ballPosX;
        for (int f = 0; f < 60; f++) begin
            frame();
            if (o_ballPosX < prev) mono = 1'b0;
            prev = o_ballPosX;
        end
        vectors++;
        if (mono !== 1'b1) begin
            errors++; $display("FAIL sat_mono: position decreased (wrap), final %0d", o_ballPosX);
        end
        vectors++;
        if (o_ballPosX !== 11'sd623 || o_ballPosY !== 11'sd240) begin
            errors++; $display("FAIL sat_pos: got %0d,%0d want 623,240", o_ballPosX, o_ballPosY);
        end
        vectors++;
        if (o_ballVelX !== 11'sd496) begin
            errors++; $display("FAIL sat_vel: got %0d want 496", o_ballVelX);
        end
        // Reset lands between edges while a frame strobe is active.
        @(posedge clk);
        #2;
        i_startOfFrame = 1'b1;
        resetN         = 1'b0;
        #1;
        vectors++;
        if (o_ballPosX !== 11'sd320 || o_ballPosY !== 11'sd240 || o_ballVelX !== 11'sd0 ||
            o_ballMoving !== 1'b0) begin
            errors++; $display("FAIL mid_reset: pos %0d,%0d vel %0d moving %0b want 320,240 0 0",
                               o_ballPosX, o_ballPosY, o_ballVelX, o_ballMoving);
        end
        i_startOfFrame = 1'b0;
        step(1);
        resetN = 1'b1;
        step(1);
        frame();
        vectors++;
        if (o_ballPosX !== 11'sd320 || o_ballVelX !== 11'sd0 || o_ballMoving !== 1'b0) begin
            errors++; $display("FAIL post_reset: pos %0d vel %0d moving %0b want 320 0 0",
                               o_ballPosX, o_ballVelX, o_ballMoving);
        end
    endtask

    task automatic test_floor();
        do_reset();
        shot(-11'sd1000, -11'sd1000);
        repeat (60) frame();
        vectors++;
        if (o_ballPosX !== 11'sd0 || o_ballPosY !== 11'sd0) begin
            errors++; $display("FAIL floor_pos: got %0d,%0d want 0,0", o_ballPosX, o_ballPosY);
        end
        vectors++;
        if (o_ballVelX !== -11'sd496 || o_ballVelY !== -11'sd496) begin
            errors++; $display("FAIL floor_vel: got %0d/%0d want -496/-496", o_ballVelX, o_ballVelY);
        end
    endtask

    initial begin
        test_reset();
        test_shot();
        test_stop();
        test_clamp();
        test_collision_hold();
        test_coincident();
        test_saturate();
        test_floor();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
